// File: rtl/inv_pwm_pkg.sv
// inv_pwm_pkg: shared count width, limit FSM encoding and default timing values
package inv_pwm_pkg;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] PWM_GLITCH_DEF = 16'd5;
  localparam logic [CNT_W-1:0] CZ_FILT_DEF = 16'd100;
  localparam logic [CNT_W-1:0] OC_FILT_DEF = 16'd3;
  localparam logic [CNT_W-1:0] LMT_HOLD_DEF = 16'd500;
  localparam logic [7:0] LMT_FAULT_CNT_DEF = 8'd20;
  localparam logic [1:0] LMT_IDLE = 2'd0;
  localparam logic [1:0] LMT_ACTIVE = 2'd1;
  localparam logic [1:0] LMT_HOLD = 2'd2;
  localparam logic [1:0] LMT_WAIT = 2'd3;
endpackage

// File: rtl/inv_sig_filter.sv
// inv_sig_filter: 2-flop synchronizer followed by an N-cycle stability filter
module inv_sig_filter import inv_pwm_pkg::*; #(
  parameter logic [CNT_W-1:0] N = 16'd1
) (
  input  logic clk_100,
  input  logic RST,
  input  logic raw,
  output logic filt
);
  logic s1, s2, done;
  logic [CNT_W-1:0] cnt;
  // cnt holds the number of earlier disagreeing cycles, so this one is the N-th
  assign done = ({1'b0, cnt} + 17'd1) >= {1'b0, N};
  always_ff @(posedge clk_100) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      filt <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == filt) cnt <= '0;
      else if (done) begin
        filt <= s2;
        cnt <= '0;
      end else if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/inv_pwm_input_filter.sv
// inv_pwm_input_filter: filtered PWM/polarity inputs plus over-current limit FSM
// INV_LMT_FAULT_LATCH_EN enables the repeated-limit fault counter and sticky latch.
module inv_pwm_input_filter import inv_pwm_pkg::*; #(
  parameter logic [CNT_W-1:0] PWM_GLITCH = PWM_GLITCH_DEF,
  parameter logic [CNT_W-1:0] CZ_FILT = CZ_FILT_DEF,
  parameter logic [CNT_W-1:0] OC_FILT = OC_FILT_DEF,
  parameter logic [CNT_W-1:0] LMT_HOLD = LMT_HOLD_DEF,
  parameter logic [7:0] LMT_FAULT_CNT = LMT_FAULT_CNT_DEF
) (
  input  logic clk_100,
  input  logic RST,
  input  logic InvPwm_En,
  input  logic Inv_Pwm_Raw,
  input  logic Inv_CrossZero_Raw,
  input  logic Inv_OverCur_Raw,
  input  logic Fault_Clr,
  output logic Inv_Pwm_X,
  output logic Inv_CrossZero_X,
  output logic Inv_Pwm_LMTX,
  output logic Inv_Fault
);
  logic ocX, ocPrev, pwmPrev, czPrev, ocRise, pwmRise, czEdge, holdDone, limEntry;
  logic [1:0] state, stateNext;
  logic [CNT_W-1:0] holdCnt, holdNext;
  inv_sig_filter #(.N(PWM_GLITCH)) uPwm (.clk_100(clk_100), .RST(RST), .raw(Inv_Pwm_Raw), .filt(Inv_Pwm_X));
  inv_sig_filter #(.N(CZ_FILT)) uCz (.clk_100(clk_100), .RST(RST), .raw(Inv_CrossZero_Raw), .filt(Inv_CrossZero_X));
  inv_sig_filter #(.N(OC_FILT)) uOc (.clk_100(clk_100), .RST(RST), .raw(Inv_OverCur_Raw), .filt(ocX));
  assign ocRise = ocX & ~ocPrev;
  assign pwmRise = Inv_Pwm_X & ~pwmPrev;
  assign czEdge = Inv_CrossZero_X ^ czPrev;
  assign holdDone = ({1'b0, holdCnt} + 17'd1) >= {1'b0, LMT_HOLD};
  assign limEntry = (state == LMT_IDLE) && (stateNext == LMT_ACTIVE);
  always_comb begin
    stateNext = state;
    holdNext = holdCnt;
    if (!InvPwm_En) begin
      stateNext = LMT_IDLE;
      holdNext = '0;
    end else begin
      case (state)
        LMT_IDLE: stateNext = ocRise ? LMT_ACTIVE : LMT_IDLE;
        LMT_ACTIVE: if (!ocX) begin
          stateNext = inv_pwm_pkg::LMT_HOLD;
          holdNext = '0;
        end
        inv_pwm_pkg::LMT_HOLD: if (ocX) begin
          stateNext = LMT_ACTIVE;
          holdNext = '0;
        end else if (holdDone) stateNext = LMT_WAIT;
        else if (holdCnt != '1) holdNext = holdCnt + 1'b1;
        LMT_WAIT: stateNext = ocX ? LMT_ACTIVE : pwmRise ? LMT_IDLE : LMT_WAIT;
        default: stateNext = LMT_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_100) begin
    if (RST) begin
      state <= LMT_IDLE;
      holdCnt <= '0;
      ocPrev <= 1'b0;
      pwmPrev <= 1'b0;
      czPrev <= 1'b0;
    end else begin
      state <= stateNext;
      holdCnt <= holdNext;
      ocPrev <= ocX;
      pwmPrev <= Inv_Pwm_X;
      czPrev <= Inv_CrossZero_X;
    end
  end
`ifdef INV_LMT_FAULT_LATCH_EN
  logic [7:0] faultCnt, faultBase, faultNext;
  logic faultHit;
  // an entry coinciding with a cross-zero edge or clear counts as the first of a new half-cycle
  assign faultBase = (czEdge || Fault_Clr) ? 8'd0 : faultCnt;
  assign faultNext = (limEntry && faultBase != 8'hFF) ? faultBase + 1'b1 : faultBase;
  always_ff @(posedge clk_100) begin
    if (RST) begin
      faultCnt <= '0;
      faultHit <= 1'b0;
      Inv_Fault <= 1'b0;
    end else begin
      faultCnt <= faultNext;
      faultHit <= limEntry && (faultNext == LMT_FAULT_CNT);
      Inv_Fault <= faultHit | (Inv_Fault & ~Fault_Clr);
    end
  end
  assign Inv_Pwm_LMTX = (state == LMT_IDLE) && !Inv_Fault;
`else
  logic unusedSink;
  assign unusedSink = ^{Fault_Clr, limEntry, czEdge};
  assign Inv_Fault = 1'b0;
  assign Inv_Pwm_LMTX = (state == LMT_IDLE);
`endif
endmodule

// File: tb/tb_inv_pwm_input_filter.sv
// tb_inv_pwm_input_filter: directed scenarios checked every cycle against a window/timer model
module tb_inv_pwm_input_filter;
  localparam int PG = 5, CZ = 100, OC = 3, HOLD = 500, THR = 20;
`ifdef INV_LMT_FAULT_LATCH_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  logic clk_100 = 1'b0, RST = 1'b1, InvPwm_En = 1'b0, Inv_Pwm_Raw = 1'b0;
  logic Inv_CrossZero_Raw = 1'b0, Inv_OverCur_Raw = 1'b0, Fault_Clr = 1'b0;
  logic Inv_Pwm_X, Inv_CrossZero_X, Inv_Pwm_LMTX, Inv_Fault;
  int checks = 0, errors = 0, cyc = 0;
  bit [127:0] hPwm, hCz, hOc;
  bit mPwm, mCz, mOc, pPwm, pCz, pOc, lim, hit, mFault;
  int holdStart = -1, fcnt = 0;

  always #5 clk_100 = ~clk_100;

  inv_pwm_input_filter dut (
    .clk_100(clk_100), .RST(RST), .InvPwm_En(InvPwm_En), .Inv_Pwm_Raw(Inv_Pwm_Raw),
    .Inv_CrossZero_Raw(Inv_CrossZero_Raw), .Inv_OverCur_Raw(Inv_OverCur_Raw), .Fault_Clr(Fault_Clr),
    .Inv_Pwm_X(Inv_Pwm_X), .Inv_CrossZero_X(Inv_CrossZero_X), .Inv_Pwm_LMTX(Inv_Pwm_LMTX), .Inv_Fault(Inv_Fault)
  );

  // h[i] is the raw level sampled i edges ago; the output flips once the N samples
  // that have travelled through the synchronizer all show the opposite level
  function automatic bit filt(input bit [127:0] h, input int n, input bit cur);
    for (int i = 1; i <= n; i++) if (h[i] == cur) return cur;
    return ~cur;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic model();
    bit ocRise, pwmRise, czEdge, entry;
    int nc;
    if (RST) begin
      hPwm = '0; hCz = '0; hOc = '0;
      {mPwm, mCz, mOc, pPwm, pCz, pOc, lim, hit, mFault} = '0;
      holdStart = -1; fcnt = 0;
      return;
    end
    ocRise = mOc & ~pOc;
    pwmRise = mPwm & ~pPwm;
    czEdge = mCz ^ pCz;
    pOc = mOc; pPwm = mPwm; pCz = mCz;
    mPwm = filt(hPwm, PG, mPwm);
    mCz = filt(hCz, CZ, mCz);
    mOc = filt(hOc, OC, mOc);
    hPwm = {hPwm[126:0], Inv_Pwm_Raw};
    hCz = {hCz[126:0], Inv_CrossZero_Raw};
    hOc = {hOc[126:0], Inv_OverCur_Raw};
    entry = 1'b0;
    if (!InvPwm_En) lim = 1'b0;
    else if (!lim) begin
      if (ocRise) begin lim = 1'b1; holdStart = -1; entry = 1'b1; end
    end else if (pOc) holdStart = -1;
    else if (holdStart < 0) holdStart = cyc;
    else if (cyc - holdStart > HOLD && pwmRise) lim = 1'b0;
    if (FAULT_EN) begin
      if (hit) mFault = 1'b1;
      else if (Fault_Clr) mFault = 1'b0;
      nc = (czEdge || Fault_Clr) ? 0 : fcnt;
      if (entry && nc < 255) nc++;
      hit = entry && nc == THR;
      fcnt = nc;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100);
      cyc++;
      model();
      #1;
      chk("pwm_x", Inv_Pwm_X, mPwm);
      chk("cz_x", Inv_CrossZero_X, mCz);
      chk("lmtx", Inv_Pwm_LMTX, !lim && !mFault);
      chk("fault", Inv_Fault, mFault);
    end
  endtask

  task automatic entryPulse();
    InvPwm_En = 1'b1; Inv_OverCur_Raw = 1'b1; tick(8);
    Inv_OverCur_Raw = 1'b0; tick(8);
    InvPwm_En = 1'b0; tick(2);
    InvPwm_En = 1'b1;
  endtask

  task automatic releaseAfter(input int n);
    tick(n);
    Inv_Pwm_Raw = 1'b1; tick(7);
    chk("lmtx_until_pwm", Inv_Pwm_LMTX, 1'b0);
    tick(1);
    chk("lmtx_release", Inv_Pwm_LMTX, 1'b1);
    tick(5);
    Inv_Pwm_Raw = 1'b0; tick(12);
  endtask

  initial begin
    tick(3);
    chk("rst_pwm", Inv_Pwm_X, 1'b0);
    chk("rst_cz", Inv_CrossZero_X, 1'b0);
    chk("rst_lmtx", Inv_Pwm_LMTX, 1'b1);
    chk("rst_fault", Inv_Fault, 1'b0);
    RST = 1'b0; tick(5);
    Inv_Pwm_Raw = 1'b1; tick(4); Inv_Pwm_Raw = 1'b0; tick(12);
    chk("pwm_glitch4", Inv_Pwm_X, 1'b0);
    Inv_Pwm_Raw = 1'b1; tick(5); Inv_Pwm_Raw = 1'b0; tick(1);
    chk("pwm_raw6", Inv_Pwm_X, 1'b0);
    tick(1);
    chk("pwm_raw7", Inv_Pwm_X, 1'b1);
    tick(12);
    chk("pwm_fall", Inv_Pwm_X, 1'b0);
    InvPwm_En = 1'b1; tick(2);
    Inv_OverCur_Raw = 1'b1; tick(5);
    chk("lmtx_raw5", Inv_Pwm_LMTX, 1'b1);
    tick(1);
    chk("lmtx_raw6", Inv_Pwm_LMTX, 1'b0);
    tick(44); Inv_OverCur_Raw = 1'b0;
    releaseAfter(560);
    Inv_OverCur_Raw = 1'b1; tick(20); Inv_OverCur_Raw = 1'b0; tick(306);
    Inv_OverCur_Raw = 1'b1; tick(10); Inv_OverCur_Raw = 1'b0; tick(250);
    Inv_Pwm_Raw = 1'b1; tick(10); Inv_Pwm_Raw = 1'b0; tick(10);
    chk("hold_restart", Inv_Pwm_LMTX, 1'b0);
    releaseAfter(300);
    repeat (20) entryPulse();
    tick(3);
    chk("fault_set", Inv_Fault, FAULT_EN);
    chk("fault_lmtx", Inv_Pwm_LMTX, !FAULT_EN);
    Fault_Clr = 1'b1; tick(1); Fault_Clr = 1'b0; tick(2);
    chk("fault_clr", Inv_Fault, 1'b0);
    chk("fault_clr_lmtx", Inv_Pwm_LMTX, 1'b1);
    Inv_OverCur_Raw = 1'b1; tick(20); Inv_OverCur_Raw = 1'b0;
    releaseAfter(560);
    Inv_CrossZero_Raw = 1'b1; tick(110);
    chk("cz_rise", Inv_CrossZero_X, 1'b1);
    repeat (19) entryPulse();
    Inv_CrossZero_Raw = 1'b0; tick(110);
    chk("cz_fall", Inv_CrossZero_X, 1'b0);
    repeat (19) entryPulse();
    tick(3);
    chk("fault_19_19", Inv_Fault, 1'b0);
    Inv_OverCur_Raw = 1'b1; tick(20); Inv_OverCur_Raw = 1'b0; tick(100);
    chk("lmtx_in_hold", Inv_Pwm_LMTX, 1'b0);
    Inv_Pwm_Raw = 1'b1; tick(10);
    RST = 1'b1; tick(1);
    chk("rst_hold_lmtx", Inv_Pwm_LMTX, 1'b1);
    chk("rst_hold_pwm", Inv_Pwm_X, 1'b0);
    chk("rst_hold_cz", Inv_CrossZero_X, 1'b0);
    chk("rst_hold_fault", Inv_Fault, 1'b0);
    RST = 1'b0; Inv_Pwm_Raw = 1'b0; tick(12);
    Inv_OverCur_Raw = 1'b1; tick(8);
    chk("lmtx_active", Inv_Pwm_LMTX, 1'b0);
    InvPwm_En = 1'b0; tick(1);
    chk("en_drop", Inv_Pwm_LMTX, 1'b1);
    Inv_OverCur_Raw = 1'b0; InvPwm_En = 1'b1; tick(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_pwm_input_filter.md
INV_PWM_INPUT_FILTER -- requirements
Module: inv_pwm_input_filter

Interface
REQ-001 SHALL have parameter PWM_GLITCH, 16'd5: filter length for the PWM input, in clk_100 cycles.
REQ-002 SHALL have parameter CZ_FILT, 16'd100: filter length for the cross-zero input.
REQ-003 SHALL have parameter OC_FILT, 16'd3: filter length for the over-current input.
REQ-004 SHALL have parameter LMT_HOLD, 16'd500: minimum limit hold time after over-current clears (5 us).
REQ-005 SHALL have parameter LMT_FAULT_CNT, 8'd20: number of limit entries per half-cycle that trips the fault.
REQ-006 SHALL have port clk_100, input, 1 bit: the single 100 MHz clock.
REQ-007 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port InvPwm_En, input, 1 bit: inverter PWM enable.
REQ-009 SHALL have port Inv_Pwm_Raw, input, 1 bit: asynchronous PWM from the DSP.
REQ-010 SHALL have port Inv_CrossZero_Raw, input, 1 bit: asynchronous polarity from the DSP.
REQ-011 SHALL have port Inv_OverCur_Raw, input, 1 bit: asynchronous over-current comparator, active-high.
REQ-012 SHALL have port Fault_Clr, input, 1 bit: single-cycle pulse that clears Inv_Fault.
REQ-013 SHALL have port Inv_Pwm_X, output, 1 bit: filtered PWM.
REQ-014 SHALL have port Inv_CrossZero_X, output, 1 bit: filtered polarity.
REQ-015 SHALL have port Inv_Pwm_LMTX, output, 1 bit: current limit, active-low (0 = limit).
REQ-016 SHALL have port Inv_Fault, output, 1 bit: sticky repeated-limit fault.

Function
REQ-017 Each raw input SHALL pass through a 2-flop synchronizer, then a stability filter of length N.
REQ-018 Stability filter: output SHALL toggle only after the synchronized value differs from the output for N consecutive cycles; the counter clears on any disagreement break.
- Latency from raw edge to output edge is 2+N cycles.
- A pulse of N-1 cycles or less is suppressed.
REQ-019 Filter counters SHALL saturate and never wrap.
REQ-020 Limit FSM SHALL have exactly these states:
- LMT_IDLE: LMTX=1.
- LMT_ACTIVE: LMTX=0.
- LMT_HOLD: LMTX=0, hold counter runs.
- LMT_WAIT: LMTX=0, waits for a PWM rising edge.
REQ-021 LMT_IDLE SHALL go to LMT_ACTIVE on a filtered over-current rising edge while InvPwm_En=1.
REQ-022 LMT_ACTIVE SHALL go to LMT_HOLD when filtered over-current=0, with the hold counter cleared.
REQ-023 LMT_HOLD SHALL go to LMT_WAIT after LMT_HOLD cycles, and SHALL return to LMT_ACTIVE if over-current reasserts, with the counter cleared.
REQ-024 LMT_WAIT SHALL go to LMT_IDLE in the cycle after a filtered Inv_Pwm_X rising edge, and SHALL return to LMT_ACTIVE if over-current reasserts.
REQ-025 InvPwm_En=0 SHALL force LMT_IDLE and clear the hold counter in the next cycle, from any state.
REQ-026 Fault counter (8 bit, saturating) SHALL increment on each LMT_IDLE->LMT_ACTIVE entry and clear on every filtered Inv_CrossZero_X edge.
- If an entry and a cross-zero edge occur in the same cycle, the counter SHALL become 1.
REQ-027 Counter reaching LMT_FAULT_CNT SHALL set Inv_Fault in the next cycle.
REQ-028 Inv_Fault=1 SHALL force Inv_Pwm_LMTX=0 regardless of FSM state.
REQ-029 Fault_Clr SHALL clear Inv_Fault and the fault counter.
- If Fault_Clr and a set condition coincide, set wins.
REQ-030 Inv_Pwm_X and Inv_CrossZero_X SHALL be filtered irrespective of InvPwm_En.

Reset
REQ-031 RST=1 at a clk_100 edge SHALL clear all synchronizers, filter counters, hold counter and fault counter, and select LMT_IDLE.
REQ-032 Output reset values SHALL be: Inv_Pwm_X=0, Inv_CrossZero_X=0, Inv_Pwm_LMTX=1, Inv_Fault=0.
REQ-033 Reset mid-limit or mid-fault SHALL take effect in the same cycle, with no hold time honoured.

Configuration
REQ-034 Macro INV_LMT_FAULT_LATCH_EN SHALL select the fault logic at compile time.
- Defined: REQ-026..029 are implemented.
- Undefined: fault counter and latch are absent, Inv_Fault is tied 0, Fault_Clr is ignored, and LMTX follows the FSM only.

Structure
REQ-035 Shared package inv_pwm_pkg SHALL hold the limit FSM state encoding, the 16-bit count width constant and the default parameter values.
REQ-036 One sub-module, inv_sig_filter (2-flop synchronizer plus length-N stability filter, with parameter N), SHALL be instantiated three times.

Verification
REQ-037 Bench SHALL cover these directed scenarios:
- Inv_Pwm_Raw pulse of 4 cycles -> Inv_Pwm_X unchanged; pulse of 5 cycles -> Inv_Pwm_X rises exactly 7 cycles after the raw edge.
- En=1, over-current high 50 cycles -> LMTX=0 at raw+6, held through 500 hold cycles, released the cycle after the next filtered PWM rising edge.
- Over-current reasserts at hold count 300 -> FSM back to LMT_ACTIVE, hold restarts from 0, LMTX stays 0 throughout.
- 20 limit entries with no cross-zero edge -> Inv_Fault=1 and LMTX=0 persist; Fault_Clr pulse -> Inv_Fault=0, next PWM-aligned release works.
- 19 entries, a cross-zero edge, then 19 entries -> Inv_Fault stays 0; macro undefined -> Inv_Fault=0 always.
- RST asserted in LMT_HOLD -> next cycle LMTX=1, all outputs at reset values; En dropped in LMT_ACTIVE -> LMTX=1 the next cycle.
